// File: rtl/pc_unit.sv
// Program-counter unit for the multi-cycle MIPS core.
// Holds the fetch address and picks the next one by fixed priority:
// exception, eret, return, call/jump, branch, then sequential.
// A small circular return-address stack serves jr $ra.
// An exception PC register saves the faulting address.
// A misaligned return/jump/branch target is turned into an exception.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0180),
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcen,
    input  logic             exc_req,
    input  logic             eret,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    input  logic             call,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_hit,
    output logic             misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    // Word-aligned targets only; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
        return |addr[1:0];
    endfunction

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] ras_cnt;

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] redirect;
    logic             redirect_en;
    logic             take_exc;
    logic             mis_req;
    logic             push_req;
    logic             pop_req;

    assign seq_pc    = pc + WIDTH'(STEP);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_MAX);

    // Priority select of the next fetch address and the RAS side effects.
    always_comb begin
        next_pc     = seq_pc;
        redirect    = '0;
        redirect_en = 1'b0;
        take_exc    = 1'b0;
        mis_req     = 1'b0;
        push_req    = 1'b0;
        pop_req     = 1'b0;
        ras_hit     = 1'b0;
        if (exc_req) begin
            next_pc  = EXC_VEC;
            take_exc = 1'b1;
        end else if (eret) begin
            next_pc = epc;
        end else begin
            if (ret) begin
                redirect_en = 1'b1;
                ras_hit     = !ras_empty;
                pop_req     = !ras_empty;
                redirect    = ras_empty ? ret_target : ras_mem[top_ptr];
            end else if (call || jump) begin
                redirect_en = 1'b1;
                push_req    = call;
                redirect    = jump_target;
            end else if (branch_en) begin
                redirect_en = 1'b1;
                redirect    = branch_target;
            end
            if (redirect_en) begin
                if (is_misaligned(redirect)) begin
                    // A bad target becomes an exception and touches no RAS state.
                    next_pc  = EXC_VEC;
                    take_exc = 1'b1;
                    mis_req  = 1'b1;
                    push_req = 1'b0;
                    pop_req  = 1'b0;
                end else begin
                    next_pc = redirect;
                end
            end
        end
    end

    // Fetch address, exception PC and the one-cycle misalign pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VEC;
            epc      <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= pcen && mis_req;
            if (pcen) begin
                pc <= next_pc;
                if (take_exc) begin
                    epc <= pc;
                end
            end
        end
    end

    // RAS pointer and occupancy; a push when full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            ras_cnt <= '0;
        end else if (pcen) begin
            if (push_req) begin
                top_ptr <= top_ptr + PTR_W'(1);
                if (!ras_full) begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end else if (pop_req) begin
                top_ptr <= top_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // RAS storage; contents are don't-care after reset so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && pcen && push_req) begin
            ras_mem[top_ptr + PTR_W'(1)] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: vector table driven at the falling edge, with
// combinational outputs compared immediately and registered results
// queued for comparison just after the committing rising edge.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pcen = 1'b0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] ret_target = '0;
    logic        call = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_hit;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .pcen(pcen), .exc_req(exc_req), .eret(eret),
        .ret(ret), .ret_target(ret_target), .call(call), .jump(jump),
        .jump_target(jump_target), .branch_en(branch_en),
        .branch_target(branch_target), .pc(pc), .next_pc(next_pc), .epc(epc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_hit(ras_hit),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pcen, exc, eret, ret;
        logic [31:0] rt;
        logic        call, jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        chk;
        logic [31:0] e_next;
        logic        e_hit;
        logic [31:0] e_pc, e_epc;
        logic        e_empty, e_full, e_mis;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic pe, input logic ex, input logic er,
        input logic rt_, input logic [31:0] rtv, input logic cl, input logic jp,
        input logic [31:0] jtv, input logic b, input logic [31:0] btv,
        input logic c, input logic [31:0] nx, input logic h,
        input logic [31:0] p, input logic [31:0] e,
        input logic em, input logic fu, input logic mi);
        vec_t v;
        v.rst = r; v.pcen = pe; v.exc = ex; v.eret = er; v.ret = rt_; v.rt = rtv;
        v.call = cl; v.jump = jp; v.jt = jtv; v.br = b; v.bt = btv;
        v.chk = c; v.e_next = nx; v.e_hit = h; v.e_pc = p; v.e_epc = e;
        v.e_empty = em; v.e_full = fu; v.e_mis = mi;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t vecs[$];
    vec_t sb[$];

    // Scoreboard: compare registered state just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            cmp("pc", pc, e.e_pc);
            cmp("epc", epc, e.e_epc);
            cmp("ras_empty", 32'(ras_empty), 32'(e.e_empty));
            cmp("ras_full", 32'(ras_full), 32'(e.e_full));
            cmp("misalign", 32'(misalign), 32'(e.e_mis));
        end
    end

    initial begin
        // rst pcen exc eret ret rt  call jump jt  br bt | chk next hit | pc epc empty full mis
        vecs.push_back(mk(1,0,0,0,0,0,     0,0,0,          0,0,     0,0,0,          0,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,0,          0,0,     1,32'h4,0,      32'h4,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,0,          0,0,     1,32'h8,0,      32'h8,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,0,          0,0,     1,32'hC,0,      32'hC,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,1,32'hFFFFFFFC,0,0,    1,32'hFFFFFFFC,0, 32'hFFFFFFFC,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,0,          0,0,     1,32'h0,0,      32'h0,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h40,     0,0,     1,32'h40,0,     32'h40,0,0,0,0));
        vecs.push_back(mk(0,1,1,0,1,32'h900,0,1,32'h300,   1,32'h500, 1,32'h180,0,  32'h180,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h900,0,0,0,         0,0,     1,32'h4,1,      32'h4,32'h40,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,1,32'h100,    0,0,     1,32'h100,0,    32'h100,32'h40,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h200,    0,0,     1,32'h200,0,    32'h200,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h300,    0,0,     1,32'h300,0,    32'h300,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h400,    0,0,     1,32'h400,0,    32'h400,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h500,    0,0,     1,32'h500,0,    32'h500,32'h40,0,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h600,    0,0,     1,32'h600,0,    32'h600,32'h40,0,1,0));
        vecs.push_back(mk(0,1,0,0,1,32'h900,0,0,0,         0,0,     1,32'h504,1,    32'h504,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h900,0,0,0,         0,0,     1,32'h404,1,    32'h404,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h900,0,0,0,         0,0,     1,32'h304,1,    32'h304,32'h40,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h900,0,0,0,         0,0,     1,32'h204,1,    32'h204,32'h40,1,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h900,0,0,0,         0,0,     1,32'h900,0,    32'h900,32'h40,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,1,32'h10,     0,0,     1,32'h10,0,     32'h10,32'h40,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,0,          1,32'h42, 1,32'h180,0,   32'h180,32'h10,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,     0,0,0,          0,0,     1,32'h184,0,    32'h180,32'h10,1,0,0));
        vecs.push_back(mk(0,1,0,1,0,0,     0,0,0,          0,0,     1,32'h10,0,     32'h10,32'h10,1,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0,0,0, 1,0,32'h800,    0,0,     1,32'h800,0,    32'h10,32'h10,1,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h700,0,0,0,         0,0,     1,32'h700,0,    32'h700,32'h10,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h804,    0,0,     1,32'h804,0,    32'h804,32'h10,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     0,0,0,          1,32'h3, 1,32'h180,0,    32'h180,32'h804,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,     1,0,32'h900,    0,0,     1,32'h900,0,    32'h0,32'h0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,     1,0,32'h22,     0,0,     1,32'h180,0,    32'h180,32'h0,1,0,1));
        vecs.push_back(mk(0,1,0,0,1,32'h44,0,0,0,          0,0,     1,32'h44,0,     32'h44,32'h0,1,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; pcen = vecs[i].pcen; exc_req = vecs[i].exc;
            eret = vecs[i].eret; ret = vecs[i].ret; ret_target = vecs[i].rt;
            call = vecs[i].call; jump = vecs[i].jump; jump_target = vecs[i].jt;
            branch_en = vecs[i].br; branch_target = vecs[i].bt;
            #1;
            if (vecs[i].chk) begin
                cmp($sformatf("next_pc[%0d]", i), next_pc, vecs[i].e_next);
                cmp($sformatf("ras_hit[%0d]", i), 32'(ras_hit), 32'(vecs[i].e_hit));
            end
            sb.push_back(vecs[i]);
        end

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        // Back-to-back pcen: pc advances every cycle with no bubble.
        @(negedge clk);
        rst = 1'b0; pcen = 1'b1; exc_req = 1'b0; eret = 1'b0; ret = 1'b0;
        call = 1'b0; jump = 1'b0; branch_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("seq_pc[%0d]", k), pc, 32'h44 + 32'(4 * k));
        end
        @(negedge clk);
        pcen = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: time %0t, limit 20000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle MIPS core: holds the fetch address, selects the next address from sequential, branch, jump, call/return, exception and exception-return sources by fixed priority, and keeps a small return-address stack (RAS) and an exception PC (EPC). It sits between the control FSM, which issues `pcen` once per instruction, and the instruction-memory address port.

## Interface
- `WIDTH`, 32: address width in bits; 8 or more.
- `RESET_VEC`, 32'h0000_0000: value of `pc` after reset.
- `EXC_VEC`, 32'h0000_0180: exception entry address.
- `STEP`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries; power of two, 2 or more.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pcen`  in  1  commit `next_pc` into `pc` this cycle.
- `exc_req`  in  1  take an exception.
- `eret`  in  1  return from exception to `epc`.
- `ret`  in  1  return (`jr $ra`).
- `ret_target`  in  WIDTH  register value of `$ra`; used when the RAS is empty.
- `call`  in  1  `jal`: push `pc+STEP`, then jump.
- `jump`  in  1  unconditional jump.
- `jump_target`  in  WIDTH  target for `call` and `jump`.
- `branch_en`  in  1  branch taken.
- `branch_target`  in  WIDTH  branch target.
- `pc`  out  WIDTH  current fetch address (registered).
- `next_pc`  out  WIDTH  combinational address committed on the next `pcen`.
- `epc`  out  WIDTH  saved exception PC (registered).
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries.
- `ras_hit`  out  1  combinational; high when `ret` is selected and the RAS is non-empty.
- `misalign`  out  1  registered; pulses high for one cycle after a misaligned redirect is committed.

## Operation
- Source selection, highest priority first (only the winner takes effect):
  1. `exc_req`: `EXC_VEC`.
  2. `eret`: `epc`.
  3. `ret`: RAS top if the RAS is non-empty, otherwise `ret_target`.
  4. `call` or `jump`: `jump_target`.
  5. `branch_en`: `branch_target`.
  6. Otherwise: `pc+STEP`, truncated to `WIDTH` bits (wraps from all-ones to 0 with no flag).
- Misaligned redirect: if the selected source is 3, 4 or 5 and the target has bits [1:0] != 0, the redirect is converted to an exception.
  - `next_pc` = `EXC_VEC`; on commit, `epc` <= `pc` and `misalign` <= 1.
- On `pcen`, `exc_req` (or a misaligned redirect) writes `epc` <= `pc` in the same edge as `pc` <= `EXC_VEC`.
- RAS is a circular stack with a top pointer and a count from 0 to `RAS_DEPTH`.
  - Push happens only when `call` wins and `pcen` is high; the pushed value is `pc+STEP`.
  - Push when full overwrites the oldest entry; the count stays at `RAS_DEPTH`.
  - Pop happens only when `ret` wins, the RAS is non-empty, and `pcen` is high.
  - Pop when empty leaves the count at 0 and uses `ret_target`.
  - A higher-priority source winning suppresses any push or pop.
  - A misaligned `call` target suppresses the push.
- `pcen` low: no state changes, all requests are ignored, and `next_pc` and `ras_hit` still reflect the inputs.

## Timing
- Reset (`rst` high at a rising edge) sets:
  - `pc` = `RESET_VEC`, `epc` = 0, RAS count = 0, top pointer = 0, `misalign` = 0.
  - `ras_empty` = 1, `ras_full` = 0.
  - RAS entry contents are don't-care.
- `rst` has priority over `pcen`. Reset asserted mid-sequence discards pending pushes and pops.
- Latency:
  - `next_pc` is combinational from `pc`, `epc`, the RAS top and the inputs.
  - `pc` takes `next_pc` at the rising edge where `pcen` = 1, i.e. one cycle of latency.
- `misalign` is high for exactly the cycle after the committing edge, then returns to 0 unless re-triggered.
- `ras_empty` and `ras_full` are derived from the registered count and are valid in the cycle after a push or pop.
- A `pcen` pulse on consecutive cycles advances `pc` every cycle with no bubble.

## Test plan
- Sequential wrap:
  - After reset, 3 pulses of `pcen` → `pc` = 0, 4, 8, C.
  - Preload `pc` = FFFF_FFFC by jump, then `pcen` → `pc` = 0.
- Priority: `exc_req`, `ret`, `jump` and `branch_en` all high with `pcen` at `pc` = 0x40 → `pc` = 0x180, `epc` = 0x40, RAS count unchanged.
- RAS overflow, with `RAS_DEPTH` = 4:
  - 5 calls from `pc` = 0x100, 0x200, 0x300, 0x400, 0x500 → `ras_full` = 1.
  - Then 4 `ret` → `pc` = 0x504, 0x404, 0x304, 0x204, `ras_empty` = 1.
  - A 5th `ret` with `ret_target` = 0x900 → `pc` = 0x900, `ras_hit` = 0.
- Misalign: `branch_en` with target 0x0000_0042 at `pc` = 0x10 → `pc` = 0x180, `epc` = 0x10, `misalign` = 1 for one cycle; `eret` then returns `pc` to 0x10.
- Stall: `call` held high with `pcen` = 0 for 3 cycles → `pc`, RAS and `epc` unchanged, `next_pc` = `jump_target` throughout.
- Reset mid-operation: `rst` high in the same cycle as `call` + `pcen` → `pc` = `RESET_VEC`, `ras_empty` = 1, `misalign` = 0.
